pic_painter: RTL
================

// Module: pic_painter
// PURPOSE
//  Raster-scan sequencer that sits downstream of the picture loaders
//  (front/start/win/lose) and upstream of the VGA adapter. On a start
//  request it walks every pixel of the screen, drives (x,y) into the
//  loaders, and selects the requested picture's q. It then issues one VGA
//  plot per pixel, with coordinates aligned to the ROM read latency.
// PARAMETERS
//  WIDTH    160  pixels per row; rd_x/vga_x range 0..WIDTH-1
//  HEIGHT   120  rows; rd_y/vga_y range 0..HEIGHT-1
//  ROM_LAT  1    clocks from address valid to q valid at loader output (1 or 2)
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  paint request; sampled only in IDLE
//  sel         in   2  picture: 0=front 1=start 2=win 3=lose
//  q_front     in   3  colour from front loader
//  q_start     in   3  colour from start loader
//  q_win       in   3  colour from win loader
//  q_lose      in   3  colour from lose loader
//  rd_x        out  8  x to all loaders (registered)
//  rd_y        out  7  y to all loaders (registered)
//  vga_x       out  8  plot x, rd_x delayed ROM_LAT clocks
//  vga_y       out  7  plot y, rd_y delayed ROM_LAT clocks
//  vga_colour  out  3  q of latched sel (combinational mux on q_* inputs)
//  vga_plot    out  1  write strobe to VGA adapter
//  busy        out  1  high in PAINT and DRAIN
//  done        out  1  one-clock pulse when the last pixel has been plotted
// BEHAVIOUR
//  - Reset (async): state=IDLE; rd_x, rd_y, vga_x, vga_y = 0; vga_plot,
//    busy, done = 0; sel_r = 0; valid pipeline cleared. Reset mid-paint
//    aborts immediately; vga_plot drops without waiting for a clock edge.
//  - States:
//    IDLE  -> PAINT when start=1. Latch sel_r<=sel; rd=(0,0).
//    PAINT: each clock, issue the current rd coordinate with valid=1, then
//           advance x. At x=WIDTH-1, wrap x to 0 and increment y. When
//           (WIDTH-1,HEIGHT-1) is issued, go to DRAIN; rd holds its value.
//    DRAIN: ROM_LAT clocks, valid=0 issued, pipeline empties -> DONE.
//    DONE:  done=1 for exactly one clock -> IDLE.
//  - Issue order: pixel k (0..WIDTH*HEIGHT-1) is on rd in PAINT clock k
//    as (k mod WIDTH, k / WIDTH). ROM_LAT clocks later, vga_x/vga_y equal
//    that coordinate, vga_plot=1 and vga_colour = q of sel_r. The adapter
//    samples the write on that clock's rising edge.
//  - Exactly WIDTH*HEIGHT plots per paint: no duplicates, no gaps, and no
//    plot for an address outside the grid.
//  - vga_plot is high only for valid pipeline entries. It is never high in
//    IDLE or DONE.
//  - Latency: start sampled at edge E -> first plot ROM_LAT+1 clocks after
//    E. done pulses WIDTH*HEIGHT+ROM_LAT+1 clocks after E.
//  - start is ignored while busy or done is high; no queuing.
//  - sel changes after the start edge have no effect on the current paint.
//  - rd_x and rd_y are driven from counters of exactly 8 and 7 bits; no
//    intermediate wider value reaches the ports.
//  - busy=1 from the clock after start is accepted until the clock done
//    goes high. busy and done are never high together.
// TESTING
//  1 WIDTH=4,HEIGHT=3,ROM_LAT=1; start=1 one clock, sel=2 -> 12 plots in
//    order (0,0),(1,0)..(3,2). vga_colour==q_win each time. done at +14.
//  2 Default params, sel=0, ROM model returns x^y[2:0] -> 19200 plots, all
//    colours match, no duplicate coordinates, done exactly once.
//  3 ROM_LAT=2, WIDTH=4,HEIGHT=3 -> first plot 3 clocks after start edge,
//    plotted coordinate equals rd from 2 clocks earlier, done at +15.
//  4 During PAINT, pulse start and change sel 2->3 -> no restart, colour
//    still q_win, still 12 plots.
//  5 Assert reset at pixel 5 of 12 -> vga_plot=0 and busy=0 asynchronously.
//    After release with start=1 -> paint restarts from (0,0).
//  6 start held high continuously -> back-to-back paints, each of 12 plots,
//    separated by a DONE clock and an IDLE clock.

Source files
------------

// File: rtl/pic_painter.sv
// Raster-scan sequencer: walks every pixel once per paint request, addresses the
// picture loaders and issues one VGA plot per pixel aligned to the ROM latency.
module pic_painter #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int ROM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [2:0] q_front,
  input  logic [2:0] q_start,
  input  logic [2:0] q_win,
  input  logic [2:0] q_lose,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PAINT, DRAIN, DONE} state_t;

  localparam logic [7:0] X_LAST     = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST     = 7'(HEIGHT - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);

  state_t       state_q, state_d;
  logic [7:0]   rd_x_q, rd_x_d;
  logic [6:0]   rd_y_q, rd_y_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   drain_q, drain_d;

  logic [7:0]         x_p_q [ROM_LAT];
  logic [7:0]         x_p_d [ROM_LAT];
  logic [6:0]         y_p_q [ROM_LAT];
  logic [6:0]         y_p_d [ROM_LAT];
  logic [ROM_LAT-1:0] vld_p_q, vld_p_d;

  always_comb begin
    state_d = state_q;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    sel_d   = sel_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PAINT;
          sel_d   = sel;
          rd_x_d  = 8'd0;
          rd_y_d  = 7'd0;
        end
      end
      PAINT: begin
        // The final coordinate stays on rd while the pipeline drains.
        if (rd_x_q == X_LAST) begin
          if (rd_y_q == Y_LAST) begin
            state_d = DRAIN;
            drain_d = 2'd0;
          end else begin
            rd_x_d = 8'd0;
            rd_y_d = rd_y_q + 7'd1;
          end
        end else begin
          rd_x_d = rd_x_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coordinate/valid delay line matching the loader read latency.
  always_comb begin
    x_p_d[0]   = rd_x_q;
    y_p_d[0]   = rd_y_q;
    vld_p_d    = '0;
    vld_p_d[0] = (state_q == PAINT);
    for (int i = 1; i < ROM_LAT; i++) begin
      x_p_d[i]   = x_p_q[i-1];
      y_p_d[i]   = y_p_q[i-1];
      vld_p_d[i] = vld_p_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_x_q  <= 8'd0;
      rd_y_q  <= 7'd0;
      sel_q   <= 2'd0;
      drain_q <= 2'd0;
      vld_p_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        x_p_q[i] <= 8'd0;
        y_p_q[i] <= 7'd0;
      end
    end else begin
      state_q <= state_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      sel_q   <= sel_d;
      drain_q <= drain_d;
      vld_p_q <= vld_p_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        x_p_q[i] <= x_p_d[i];
        y_p_q[i] <= y_p_d[i];
      end
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    vga_colour = q_front;
      2'd1:    vga_colour = q_start;
      2'd2:    vga_colour = q_win;
      default: vga_colour = q_lose;
    endcase
  end

  assign rd_x     = rd_x_q;
  assign rd_y     = rd_y_q;
  assign vga_x    = x_p_q[ROM_LAT-1];
  assign vga_y    = y_p_q[ROM_LAT-1];
  assign vga_plot = vld_p_q[ROM_LAT-1];
  assign busy     = (state_q == PAINT) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

endmodule
